// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter: shares the single user_io SD sector port between
// DRIVE_N emulated drives. Round-robin grant, LBA forwarding, buffer
// routing to the granted drive, request timeout and stretched LED.
module sd_drive_arbiter #(
  parameter int DRIVE_N  = 1,        // number of drives, 1..4
  parameter int LBA_W    = 32,       // sector address width
  parameter int BUFF_AW  = 9,        // sector buffer address width (address is broadcast outside)
  parameter int TIMEOUT  = 2**24,    // cycles allowed in REQ before abort
  parameter int LED_HOLD = 2**20     // LED stretch after returning to IDLE
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [DRIVE_N-1:0]         drv_rd,
  input  logic [DRIVE_N-1:0]         drv_wr,
  input  logic [DRIVE_N*LBA_W-1:0]   drv_lba,
  output logic [DRIVE_N-1:0]         drv_ack,
  output logic [DRIVE_N-1:0]         drv_err,
  output logic [DRIVE_N-1:0]         drv_buff_wr,
  input  logic [DRIVE_N*8-1:0]       drv_buff_din,
  output logic                       sd_rd,
  output logic                       sd_wr,
  output logic [LBA_W-1:0]           sd_lba,
  input  logic                       sd_ack,
  input  logic                       sd_buff_wr,
  output logic [7:0]                 sd_buff_din,
  output logic                       busy,
  output logic                       led
);

  localparam int SEL_W = (DRIVE_N > 1) ? $clog2(DRIVE_N) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LED_W = $clog2(LED_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for any pending drive
    S_REQ,    // sd_rd/sd_wr asserted, waiting for sd_ack
    S_XFER,   // sector data moving, sd_ack high
    S_DONE    // one-cycle release before the next grant
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic               op_wr_q, op_wr_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DRIVE_N-1:0] ack_q, ack_d;
  logic [DRIVE_N-1:0] err_q, err_d;
  logic [LED_W-1:0]   led_q, led_d;

  logic [LBA_W-1:0]   lba_arr [DRIVE_N];
  logic [7:0]         din_arr [DRIVE_N];
  logic [DRIVE_N-1:0] pend;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;
  logic [DRIVE_N-1:0] sel_onehot;

  // Modulo-DRIVE_N increment used for both the search and rr_ptr advance;
  // with one drive it always folds back to 0.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int unsigned      off);
    logic [SEL_W:0] sum;
    sum = {1'b0, base} + (SEL_W+1)'(off);
    if (sum >= (SEL_W+1)'(DRIVE_N)) sum = sum - (SEL_W+1)'(DRIVE_N);
    return sum[SEL_W-1:0];
  endfunction

  for (genvar g = 0; g < DRIVE_N; g++) begin : g_unpack
    assign lba_arr[g] = drv_lba[g*LBA_W +: LBA_W];
    assign din_arr[g] = drv_buff_din[g*8 +: 8];
  end

  // Round-robin search: first pending drive at or after rr_ptr, with wrap.
  always_comb begin
    logic [SEL_W-1:0] idx;
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pend      = drv_rd | drv_wr;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    // Walk the offsets downward so the smallest offset is the one that sticks.
    for (int k = DRIVE_N-1; k >= 0; k--) begin
      idx = wrap_add(rr_q, k);
      if (pend[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Next-state and next-register logic of the arbitration FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    op_wr_d = op_wr_q;
    lba_d   = lba_q;
    tmo_d   = tmo_q;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          sel_d   = grant_idx;
          lba_d   = lba_arr[grant_idx];
          // A read wins over a write on the same drive; the write stays
          // pending and is picked up by a later grant.
          op_wr_d = ~drv_rd[grant_idx];
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          ack_d[sel_q] = 1'b1;
          state_d      = S_XFER;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d[sel_q] = 1'b1;
          rr_d         = wrap_add(sel_q, 1);
          state_d      = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_XFER: begin
        if (sd_ack) ack_d[sel_q] = 1'b1;
        else        state_d      = S_DONE;
      end
      S_DONE: begin
        rr_d    = wrap_add(sel_q, 1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LED hold counter: reloaded on every busy cycle, then counts down.
  always_comb begin
    if (state_q != S_IDLE)   led_d = LED_W'(LED_HOLD);
    else if (led_q != '0)    led_d = led_q - 1'b1;
    else                     led_d = '0;
  end

  // State register; reset aborts any transfer at once.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      op_wr_q <= 1'b0;
      lba_q   <= '0;
      tmo_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      led_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      op_wr_q <= op_wr_d;
      lba_q   <= lba_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  // One-hot of the granted drive for buffer strobe routing.
  always_comb begin
    sel_onehot        = '0;
    sel_onehot[sel_q] = 1'b1;
  end

  assign busy        = (state_q != S_IDLE);
  assign sd_rd       = (state_q == S_REQ) & ~op_wr_q;
  assign sd_wr       = (state_q == S_REQ) &  op_wr_q;
  assign sd_lba      = lba_q;
  assign drv_ack     = ack_q;
  assign drv_err     = err_q;
  assign drv_buff_wr = (state_q == S_XFER && sd_buff_wr) ? sel_onehot : '0;
  assign sd_buff_din = din_arr[sel_q];
  assign led         = busy | (led_q != '0);

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Testbench for sd_drive_arbiter with four drives, short timeout and LED hold.
module tb_sd_drive_arbiter;

  localparam int N     = 4;
  localparam int LBA_W = 32;
  localparam int TMO   = 16;
  localparam int HOLD  = 8;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [N-1:0]       drv_rd, drv_wr;
  logic [N*LBA_W-1:0] drv_lba;
  logic [N-1:0]       drv_ack, drv_err, drv_buff_wr;
  logic [N*8-1:0]     drv_buff_din;
  logic               sd_rd, sd_wr;
  logic [LBA_W-1:0]   sd_lba;
  logic               sd_ack, sd_buff_wr;
  logic [7:0]         sd_buff_din;
  logic               busy, led;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] lba_tab [N] = '{32'h0000_0123, 32'h0000_4567, 32'h89AB_CDEF, 32'hFFFF_FFFE};
  logic [7:0]  din_tab [N] = '{8'h11, 8'h22, 8'hA5, 8'h44};

  assign drv_lba      = {lba_tab[3], lba_tab[2], lba_tab[1], lba_tab[0]};
  assign drv_buff_din = {din_tab[3], din_tab[2], din_tab[1], din_tab[0]};

  typedef struct {
    int   drv;
    logic wr;
  } exp_t;

  typedef struct {
    logic [N-1:0] rd;
    logic [N-1:0] wr;
    int           drv;
    logic         wr_op;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs [11];

  sd_drive_arbiter #(
    .DRIVE_N (N),
    .LBA_W   (LBA_W),
    .BUFF_AW (9),
    .TIMEOUT (TMO),
    .LED_HOLD(HOLD)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .drv_rd      (drv_rd),
    .drv_wr      (drv_wr),
    .drv_lba     (drv_lba),
    .drv_ack     (drv_ack),
    .drv_err     (drv_err),
    .drv_buff_wr (drv_buff_wr),
    .drv_buff_din(drv_buff_din),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_lba      (sd_lba),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .busy        (busy),
    .led         (led)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits for the next sd request, pops the expected grant and compares it.
  task automatic wait_grant(output int drv);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    drv  = 0;
    while (!seen && lat < 20) begin
      @(negedge clk_sys);
      lat++;
      if (sd_rd || sd_wr) seen = 1'b1;
    end
    check("grant_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("grant_latency", 64'(lat), 64'd1);
      check("sb_size", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        drv = e.drv;
        check("grant_lba", 64'(sd_lba), 64'(lba_tab[e.drv]));
        check("grant_op", 64'({sd_rd, sd_wr}), 64'(e.wr ? 2'b01 : 2'b10));
        check("grant_ack_err_low", 64'({drv_ack, drv_err}), 64'd0);
        check("grant_busy_led", 64'({busy, led}), 64'(2'b11));
      end
    end
  endtask

  // Acks for len cycles with alternating buffer strobes, then follows DONE and IDLE.
  task automatic run_xfer(input int drv, input int len);
    logic [N-1:0] oh;
    int bad_ack, bad_buf;
    oh      = N'(1) << drv;
    bad_ack = 0;
    bad_buf = 0;
    sd_ack  = 1'b1;
    #1;
    check("ack_lag", 64'(drv_ack), 64'd0);
    for (int c = 0; c < len; c++) begin
      @(negedge clk_sys);
      if (drv_ack !== oh || sd_rd || sd_wr || !busy || !led || drv_err !== '0) bad_ack++;
      sd_buff_wr = c[0];
      #1;
      if (drv_buff_wr !== (c[0] ? oh : N'(0)) || sd_buff_din !== din_tab[drv]) bad_buf++;
    end
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    check("xfer_ack_follow", 64'(bad_ack), 64'd0);
    check("xfer_buff_route", 64'(bad_buf), 64'd0);
    @(negedge clk_sys);
    check("done_ack_busy", 64'({drv_ack, busy}), 64'({N'(0), 1'b1}));
    @(negedge clk_sys);
    check("idle_after_done", 64'({drv_ack, busy, sd_rd, sd_wr}), 64'd0);
  endtask

  task automatic serve(input int len);
    int d;
    wait_grant(d);
    run_xfer(d, len);
  endtask

  initial begin
    int d;
    int cnt;

    vecs[0]  = '{4'b1111, 4'b0000, 1, 1'b0};   // round-robin continues 1,2,3,0
    vecs[1]  = '{4'b1111, 4'b0000, 2, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0000, 3, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0000, 0, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0100, 2, 1'b1};   // drive 2 write, buffer routing
    vecs[5]  = '{4'b0001, 4'b0000, 0, 1'b0};   // wrap from rr=3 to drive 0
    vecs[6]  = '{4'b0010, 4'b0010, 1, 1'b0};   // rd+wr together: read first
    vecs[7]  = '{4'b0000, 4'b0010, 1, 1'b1};   // then the write
    vecs[8]  = '{4'b1001, 4'b0000, 3, 1'b0};
    vecs[9]  = '{4'b1001, 4'b0000, 0, 1'b0};
    vecs[10] = '{4'b0000, 4'b1000, 3, 1'b1};

    reset_n    = 1'b0;
    drv_rd     = '1;
    drv_wr     = '0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs",
          64'({sd_rd, sd_wr, sd_lba, drv_ack, drv_err, busy, led, drv_buff_wr}), 64'd0);
    drv_rd  = '0;
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single long read on drive 0.
    drv_rd = 4'b0001;
    exp_q.push_back('{0, 1'b0});
    serve(512);
    drv_rd = '0;

    // Table-driven grants; masks change only once the arbiter is back in IDLE.
    for (int i = 0; i < 11; i++) begin
      drv_rd = vecs[i].rd;
      drv_wr = vecs[i].wr;
      exp_q.push_back('{vecs[i].drv, vecs[i].wr_op});
      serve(16);
    end
    drv_rd = '0;
    drv_wr = '0;

    // Timeout on drive 2: 16 REQ cycles, error pulse, rr_ptr moves to 3.
    drv_rd = 4'b0100;
    exp_q.push_back('{2, 1'b0});
    wait_grant(d);
    cnt = 1;
    while (sd_rd && cnt < 40) begin
      @(negedge clk_sys);
      if (sd_rd) cnt++;
    end
    check("timeout_cycles", 64'(cnt), 64'(TMO));
    check("timeout_err_pulse", 64'(drv_err), 64'(4'b0100));
    check("timeout_idle", 64'({busy, drv_ack, sd_wr}), 64'd0);
    drv_rd = 4'b1100;
    exp_q.push_back('{3, 1'b0});
    serve(16);
    drv_rd = '0;

    // Buffer isolation while idle.
    sd_buff_wr = 1'b1;
    #1;
    check("idle_buff_wr_iso", 64'(drv_buff_wr), 64'd0);
    check("idle_buff_din_sel", 64'(sd_buff_din), 64'(din_tab[3]));
    sd_buff_wr = 1'b0;

    // Request dropped right after grant still completes; then LED stretch.
    drv_rd = 4'b0100;
    exp_q.push_back('{2, 1'b0});
    wait_grant(d);
    drv_rd = '0;
    run_xfer(d, 16);
    cnt = 0;
    while (led && cnt < 40) begin
      cnt++;
      @(negedge clk_sys);
    end
    check("led_hold_cycles", 64'(cnt), 64'(HOLD));
    check("no_regrant", 64'(busy), 64'd0);

    // Reset in the middle of a transfer, then regrant from index 0.
    drv_rd = 4'b1010;
    exp_q.push_back('{3, 1'b0});
    wait_grant(d);
    sd_ack = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("xfer_before_reset", 64'(drv_ack), 64'(4'b1000));
    sd_buff_wr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async",
          64'({sd_rd, sd_wr, sd_lba, drv_ack, drv_err, busy, led, drv_buff_wr}), 64'd0);
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_q.push_back('{1, 1'b0});
    serve(16);
    drv_rd = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
- Shares the single user_io SD sector interface between DRIVE_N emulated disk drives, generalising the current one-drive hookup to 1..4 drives.
- Sits between the drive instances and user_io inside c64_mist.
- Arbitrates read/write sector requests round-robin, forwards the LBA, and routes buffer traffic to the granted drive only.
- Adds a request timeout with a per-drive error pulse and a stretched activity LED.

Parameters:
DRIVE_N, 1, number of drives, 1..4
LBA_W, 32, sector address width
BUFF_AW, 9, sector buffer address width (512 bytes)
TIMEOUT, 2**24, clk_sys cycles allowed in REQ before abort
LED_HOLD, 2**20, cycles the LED stays on after the arbiter returns to IDLE

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
drv_rd  in  DRIVE_N  per-drive read request (level)
drv_wr  in  DRIVE_N  per-drive write request (level)
drv_lba  in  DRIVE_N*LBA_W  per-drive LBA; drive i uses bits [i*LBA_W +: LBA_W]
drv_ack  out  DRIVE_N  per-drive acknowledge
drv_err  out  DRIVE_N  one-cycle timeout pulse
drv_buff_wr  out  DRIVE_N  buffer write strobe, granted drive only
drv_buff_din  in  DRIVE_N*8  per-drive buffer read data (write path)
sd_rd  out  1  read request to user_io
sd_wr  out  1  write request to user_io
sd_lba  out  LBA_W  LBA to user_io
sd_ack  in  1  user_io transfer acknowledge
sd_buff_wr  in  1  user_io buffer write strobe
sd_buff_din  out  8  granted drive's buffer data to user_io
busy  out  1  high whenever state is not IDLE
led  out  1  stretched activity indicator

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr=0, sel=0. sd_rd, sd_wr, sd_lba, drv_ack, drv_err, busy and led all 0. Reset during any state aborts the transfer immediately.
- Request and priority rules:
  - pend[i] = drv_rd[i] | drv_wr[i].
  - If both are high on one drive, the read is issued first. The write stays pending and is served on a later grant.
- IDLE:
  - If any pend bit is set, choose the first pending index starting at rr_ptr and searching upward with wrap-around.
  - Register sel, sd_lba = drv_lba[sel], and op (read or write).
  - Next cycle: assert sd_rd or sd_wr, go to REQ. Grant-to-request latency is 1 cycle.
- REQ:
  - Hold sd_rd/sd_wr and sd_lba stable while the timeout counter increments.
  - On the cycle sd_ack is first sampled high: drop sd_rd/sd_wr, go to XFER.
  - If the counter reaches TIMEOUT-1 first: drop the request, pulse drv_err[sel] for 1 cycle, set rr_ptr=sel+1 mod DRIVE_N, go to IDLE.
- XFER:
  - drv_ack[sel] = sd_ack, registered with 1 cycle latency; all other drv_ack bits are 0.
  - drv_buff_wr[sel] = sd_buff_wr, combinational.
  - sd_buff_din = drv_buff_din[sel], combinational.
  - Buffer address and dout are broadcast outside this block.
  - On sd_ack low: go to DONE.
- DONE: 1 cycle; drv_ack[sel]=0; rr_ptr=sel+1 mod DRIVE_N; go to IDLE. The earliest re-grant is the following cycle.
- Request changes: a drive dropping its request during REQ does not cancel it; the transfer proceeds. Requests arriving during a transfer wait for IDLE.
- Buffer isolation: outside XFER, drv_buff_wr=0 and sd_buff_din=drv_buff_din[sel].
- DRIVE_N=1: rr_ptr is constant 0 and sel is always 0.
- led: set while busy, with a hold counter loaded with LED_HOLD on every busy cycle. After busy falls, led stays high for exactly LED_HOLD cycles.
- Timeout counter: ceil(log2(TIMEOUT)) bits, cleared on entry to REQ.

Test Plan:
- Single read: DRIVE_N=2, drv_rd=2'b01, lba0=0x123 → sd_rd high 1 cycle later with sd_lba=0x123; sd_ack high 512 cycles → drv_ack[0] follows with 1-cycle lag; drv_ack[1]=0; state returns to IDLE.
- Round-robin: DRIVE_N=4, all four drv_rd held high → grant order 0,1,2,3,0; each sd_lba matches drv_lba[sel].
- Buffer routing: drive2 granted, write op; drv_buff_din[2]=0xA5, others 0x00 → sd_buff_din=0xA5; sd_buff_wr pulses appear only on drv_buff_wr[2].
- Rd+wr together: drive1 has drv_rd=drv_wr=1 → read transaction first, then write transaction on the next grant.
- Timeout: TIMEOUT=16, request with sd_ack held low → sd_rd drops after 16 cycles in REQ; drv_err[sel] pulses 1 cycle; rr_ptr advances.
- Reset mid-XFER: reset_n low during XFER → all outputs 0 asynchronously; after release, a pending drive is regranted starting from index 0.
